// File: rtl/store_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_port_arbiter_pkg
// Description : Shared types for the store-port arbiter (request, tag, FSM).
// Revision    : 1.0  initial release
// ============================================================================
package store_port_arbiter_pkg;

    localparam int c_NUM_TAGS = 4;
    localparam int c_ID_W     = 6;

    typedef logic [c_ID_W-1:0]              StID_t;
    typedef logic [$clog2(c_NUM_TAGS)-1:0]  StTag_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wmask;
    } SP_Req;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DRAIN     = 2'd1,
        MMIO_WAIT = 2'd2
    } SPState;

endpackage
`default_nettype wire

// File: rtl/sp_tag_alloc.sv
`default_nettype none
// ============================================================================
// Module      : sp_tag_alloc
// Description : Write-tag busy bitmap with lowest-free allocation and popcount.
// Revision    : 1.0  initial release
// ============================================================================
module sp_tag_alloc #(
    parameter  int NUM_TAGS = 4,
    localparam int c_TAG_W  = $clog2(NUM_TAGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_alloc,
    input  logic               i_free,
    input  logic [c_TAG_W-1:0] i_freeTag,
    output logic [NUM_TAGS-1:0] o_busy,
    output logic [c_TAG_W-1:0] o_allocTag,
    output logic               o_anyFree,
    output logic [c_TAG_W:0]   o_count,
    output logic               o_emptyNext
);

    logic [NUM_TAGS-1:0] r_busy;
    logic [NUM_TAGS-1:0] w_busyNext;
    logic [c_TAG_W-1:0]  w_allocTag;
    logic [c_TAG_W:0]    w_count;

    // Allocation looks only at the registered bitmap, so a tag freed this
    // cycle cannot be handed out again until the next one.
    always_comb begin
        w_allocTag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_allocTag = i[c_TAG_W-1:0];
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_count = w_count + (c_TAG_W+1)'(r_busy[i]);
        end
    end

    always_comb begin
        w_busyNext = r_busy;
        if (i_free)  w_busyNext[i_freeTag]  = 1'b0;
        if (i_alloc) w_busyNext[w_allocTag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busyNext;
    end

    assign o_busy      = r_busy;
    assign o_allocTag  = w_allocTag;
    assign o_anyFree   = ~&r_busy;
    assign o_count     = w_count;
    assign o_emptyNext = ~|w_busyNext;

endmodule
`default_nettype wire

// File: rtl/store_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : store_port_arbiter
// Description : Shares the cache/MMIO write port between store queue and aux
//               writer, tracks tags, returns acks and serialises MMIO stores.
// Revision    : 1.0  initial release
// ============================================================================
module store_port_arbiter
    import store_port_arbiter_pkg::*;
#(
    parameter  int NUM_TAGS = c_NUM_TAGS,
    parameter  int ID_W     = c_ID_W,
    localparam int c_TAG_W  = $clog2(NUM_TAGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_sqValid,
    input  logic [ID_W-1:0]    IN_sqId,
    input  logic [31:0]        IN_sqAddr,
    input  logic [31:0]        IN_sqData,
    input  logic [3:0]         IN_sqWmask,
    input  logic               IN_sqIsMMIO,
    output logic               OUT_stallSq,
    input  logic               IN_auxValid,
    input  logic [31:0]        IN_auxAddr,
    input  logic [31:0]        IN_auxData,
    input  logic [3:0]         IN_auxWmask,
    output logic               OUT_auxReady,
    output logic               OUT_wrValid,
    output logic [31:0]        OUT_wrAddr,
    output logic [31:0]        OUT_wrData,
    output logic [3:0]         OUT_wrWmask,
    output logic [c_TAG_W-1:0] OUT_wrTag,
    input  logic               IN_wrReady,
    input  logic               IN_wrDone,
    input  logic [c_TAG_W-1:0] IN_wrDoneTag,
    input  logic               IN_wrErr,
    output logic               OUT_stAckValid,
    output logic [ID_W-1:0]    OUT_stAckId,
    output logic               OUT_auxDone,
    output logic               OUT_busErr,
    output logic               OUT_idle
);

    SPState               r_state;
    SPState               w_stateNext;
    logic                 r_lastGrantAux;
    logic [c_TAG_W-1:0]   r_mmioTag;

    logic                 r_wrValid;
    SP_Req                r_wrReq;
    logic [c_TAG_W-1:0]   r_wrTag;

    logic                 r_tagIsSq [NUM_TAGS];
    logic [ID_W-1:0]      r_tagId   [NUM_TAGS];

    logic                 r_stAckValid;
    logic [ID_W-1:0]      r_stAckId;
    logic                 r_auxDone;
    logic                 r_busErr;
    logic                 r_idle;

    logic [NUM_TAGS-1:0]  w_busy;
    logic [c_TAG_W-1:0]   w_allocTag;
    logic                 w_anyFree;
    logic [c_TAG_W:0]     w_count;
    logic                 w_emptyNext;

    logic                 w_slotFree;
    logic                 w_outZero;
    logic                 w_doneValid;
    logic                 w_sqElig;
    logic                 w_grantSq;
    logic                 w_grantAux;
    logic                 w_grant;
    SP_Req                w_req;

    assign w_slotFree  = !r_wrValid || IN_wrReady;
    assign w_outZero   = (w_count == '0);
    assign w_doneValid = IN_wrDone && w_busy[IN_wrDoneTag];
    assign w_grant     = w_grantSq || w_grantAux;

    sp_tag_alloc #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_alloc (
        .clk         (clk),
        .rst         (rst),
        .i_alloc     (w_grant),
        .i_free      (w_doneValid),
        .i_freeTag   (IN_wrDoneTag),
        .o_busy      (w_busy),
        .o_allocTag  (w_allocTag),
        .o_anyFree   (w_anyFree),
        .o_count     (w_count),
        .o_emptyNext (w_emptyNext)
    );

    // Arbitration and MMIO-ordering FSM. An MMIO store may only leave while
    // the write port is completely empty, and nothing follows it until done.
    always_comb begin
        w_stateNext = r_state;
        w_sqElig    = 1'b0;
        w_grantSq   = 1'b0;
        w_grantAux  = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    w_sqElig = IN_sqValid && (!IN_sqIsMMIO || w_outZero);
                    if (w_slotFree && w_anyFree) begin
                        if (w_sqElig && IN_auxValid) begin
                            w_grantAux = !r_lastGrantAux;
                            w_grantSq  = r_lastGrantAux;
                        end else begin
                            w_grantSq  = w_sqElig;
                            w_grantAux = IN_auxValid;
                        end
                    end
                    if (IN_sqValid && IN_sqIsMMIO) begin
                        if (!w_outZero)     w_stateNext = DRAIN;
                        else if (w_grantSq) w_stateNext = MMIO_WAIT;
                    end
                end
                DRAIN: begin
                    if (IN_sqValid && w_outZero && w_slotFree) begin
                        w_grantSq   = 1'b1;
                        w_stateNext = MMIO_WAIT;
                    end
                end
                MMIO_WAIT: begin
                    if (w_doneValid && IN_wrDoneTag == r_mmioTag) w_stateNext = RUN;
                end
                default: w_stateNext = RUN;
            endcase
        end
    end

    always_comb begin
        w_req = '{addr: IN_sqAddr, data: IN_sqData, wmask: IN_sqWmask};
        if (w_grantAux) w_req = '{addr: IN_auxAddr, data: IN_auxData, wmask: IN_auxWmask};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_lastGrantAux <= 1'b0;
            r_mmioTag      <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_grant) r_lastGrantAux <= w_grantAux;
            if (w_grantSq && w_stateNext == MMIO_WAIT) r_mmioTag <= w_allocTag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrValid <= 1'b0;
            r_wrReq   <= '0;
            r_wrTag   <= '0;
        end else if (w_grant) begin
            r_wrValid <= 1'b1;
            r_wrReq   <= w_req;
            r_wrTag   <= w_allocTag;
        end else if (IN_wrReady) begin
            r_wrValid <= 1'b0;
        end
    end

    // Owner/id entries are only meaningful while the matching busy bit is set.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tagIsSq[w_allocTag] <= w_grantSq;
            r_tagId[w_allocTag]   <= IN_sqId;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stAckValid <= 1'b0;
            r_stAckId    <= '0;
            r_auxDone    <= 1'b0;
            r_busErr     <= 1'b0;
            r_idle       <= 1'b1;
        end else begin
            r_stAckValid <= w_doneValid && r_tagIsSq[IN_wrDoneTag];
            r_auxDone    <= w_doneValid && !r_tagIsSq[IN_wrDoneTag];
            r_busErr     <= w_doneValid && IN_wrErr;
            if (w_doneValid) r_stAckId <= r_tagId[IN_wrDoneTag];
            r_idle       <= w_emptyNext && (w_stateNext == RUN);
        end
    end

    assign OUT_stallSq    = !w_grantSq;
    assign OUT_auxReady   = w_grantAux;
    assign OUT_wrValid    = r_wrValid;
    assign OUT_wrAddr     = r_wrReq.addr;
    assign OUT_wrData     = r_wrReq.data;
    assign OUT_wrWmask    = r_wrReq.wmask;
    assign OUT_wrTag      = r_wrTag;
    assign OUT_stAckValid = r_stAckValid;
    assign OUT_stAckId    = r_stAckId;
    assign OUT_auxDone    = r_auxDone;
    assign OUT_busErr     = r_busErr;
    assign OUT_idle       = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_store_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_port_arbiter
// Description : Directed scenarios plus random traffic against a queue/array
//               reference model of the store-port arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_store_port_arbiter;

    localparam int NT  = 4;
    localparam int IDW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_sqValid, IN_sqIsMMIO, IN_auxValid;
    logic [IDW-1:0] IN_sqId;
    logic [31:0] IN_sqAddr, IN_sqData, IN_auxAddr, IN_auxData;
    logic [3:0]  IN_sqWmask, IN_auxWmask;
    logic        IN_wrReady, IN_wrDone, IN_wrErr;
    logic [1:0]  IN_wrDoneTag;
    logic        OUT_stallSq, OUT_auxReady, OUT_wrValid;
    logic [31:0] OUT_wrAddr, OUT_wrData;
    logic [3:0]  OUT_wrWmask;
    logic [1:0]  OUT_wrTag;
    logic        OUT_stAckValid, OUT_auxDone, OUT_busErr, OUT_idle;
    logic [IDW-1:0] OUT_stAckId;

    always #5 clk = ~clk;

    store_port_arbiter #(.NUM_TAGS(NT), .ID_W(IDW)) dut (
        .clk(clk), .rst(rst),
        .IN_sqValid(IN_sqValid), .IN_sqId(IN_sqId), .IN_sqAddr(IN_sqAddr),
        .IN_sqData(IN_sqData), .IN_sqWmask(IN_sqWmask), .IN_sqIsMMIO(IN_sqIsMMIO),
        .OUT_stallSq(OUT_stallSq),
        .IN_auxValid(IN_auxValid), .IN_auxAddr(IN_auxAddr), .IN_auxData(IN_auxData),
        .IN_auxWmask(IN_auxWmask), .OUT_auxReady(OUT_auxReady),
        .OUT_wrValid(OUT_wrValid), .OUT_wrAddr(OUT_wrAddr), .OUT_wrData(OUT_wrData),
        .OUT_wrWmask(OUT_wrWmask), .OUT_wrTag(OUT_wrTag), .IN_wrReady(IN_wrReady),
        .IN_wrDone(IN_wrDone), .IN_wrDoneTag(IN_wrDoneTag), .IN_wrErr(IN_wrErr),
        .OUT_stAckValid(OUT_stAckValid), .OUT_stAckId(OUT_stAckId),
        .OUT_auxDone(OUT_auxDone), .OUT_busErr(OUT_busErr), .OUT_idle(OUT_idle)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0 = free running, 1 = waiting for writes to
    // drain before an MMIO store, 2 = MMIO store in flight.
    int          m_mode;
    bit          m_lastAux;
    bit          m_busy [NT];
    bit          m_isSq [NT];
    int          m_id   [NT];
    bit          m_acc  [NT];
    bit          m_wrValid;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_wmask;
    int          m_tag, m_mmioTag;
    bit          e_ack, e_auxDone, e_busErr;
    int          e_ackId;
    bit          sqTaken, auxTaken;

    task automatic model_reset();
        m_mode = 0; m_lastAux = 0; m_wrValid = 0; m_tag = 0; m_mmioTag = 0;
        e_ack = 0; e_auxDone = 0; e_busErr = 0; e_ackId = 0;
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 0; m_isSq[i] = 0; m_id[i] = 0; m_acc[i] = 0;
        end
    endtask

    task automatic model_cycle();
        int n, ft, t;
        bit slot, gSq, gAux, sqE, dv;
        n = 0; ft = -1; gSq = 0; gAux = 0;
        for (int i = 0; i < NT; i++) if (m_busy[i]) n++;
        for (int i = NT - 1; i >= 0; i--) if (!m_busy[i]) ft = i;
        slot = !m_wrValid || IN_wrReady;
        if (m_mode == 0) begin
            sqE = IN_sqValid && (!IN_sqIsMMIO || n == 0);
            if (slot && ft >= 0) begin
                if (sqE && IN_auxValid) begin gAux = !m_lastAux; gSq = m_lastAux; end
                else begin gSq = sqE; gAux = IN_auxValid; end
            end
        end else if (m_mode == 1) begin
            gSq = IN_sqValid && n == 0 && slot;
        end

        chk("stallSq", OUT_stallSq, !gSq);
        chk("auxReady", OUT_auxReady, gAux);
        chk("wrValid", OUT_wrValid, m_wrValid);
        if (m_wrValid) begin
            chk("wrAddr", OUT_wrAddr, m_addr);
            chk("wrData", OUT_wrData, m_data);
            chk("wrWmask", OUT_wrWmask, m_wmask);
            chk("wrTag", OUT_wrTag, m_tag);
        end
        chk("stAckValid", OUT_stAckValid, e_ack);
        if (e_ack) chk("stAckId", OUT_stAckId, e_ackId);
        chk("auxDone", OUT_auxDone, e_auxDone);
        chk("busErr", OUT_busErr, e_busErr);
        chk("idle", OUT_idle, n == 0 && !m_wrValid && m_mode == 0);

        t  = int'(IN_wrDoneTag);
        dv = IN_wrDone && m_busy[t];
        e_ack     = dv && m_isSq[t];
        e_auxDone = dv && !m_isSq[t];
        e_busErr  = dv && IN_wrErr;
        if (dv) e_ackId = m_id[t];
        if (m_wrValid && IN_wrReady) m_acc[m_tag] = 1;

        if (m_mode == 0 && IN_sqValid && IN_sqIsMMIO) begin
            if (n != 0) m_mode = 1;
            else if (gSq) begin m_mode = 2; m_mmioTag = ft; end
        end else if (m_mode == 1 && gSq) begin
            m_mode = 2; m_mmioTag = ft;
        end else if (m_mode == 2 && dv && t == m_mmioTag) begin
            m_mode = 0;
        end

        if (dv) begin m_busy[t] = 0; m_acc[t] = 0; end
        if (gSq || gAux) begin
            m_busy[ft] = 1; m_isSq[ft] = gSq; m_id[ft] = int'(IN_sqId); m_acc[ft] = 0;
            m_wrValid = 1; m_tag = ft; m_lastAux = gAux;
            m_addr  = gSq ? IN_sqAddr  : IN_auxAddr;
            m_data  = gSq ? IN_sqData  : IN_auxData;
            m_wmask = gSq ? IN_sqWmask : IN_auxWmask;
        end else if (IN_wrReady) begin
            m_wrValid = 0;
        end
        sqTaken = gSq; auxTaken = gAux;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("stallSq_in_rst", OUT_stallSq, 1'b1);
            chk("auxReady_in_rst", OUT_auxReady, 1'b0);
            model_reset();
            sqTaken = 0; auxTaken = 0;
        end else begin
            model_cycle();
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic quiet_inputs();
        IN_sqValid = 0; IN_sqIsMMIO = 0; IN_auxValid = 0;
        IN_wrReady = 1; IN_wrDone = 0; IN_wrErr = 0; IN_wrDoneTag = 0;
    endtask

    task automatic sq_drive(input int id, input logic [31:0] addr, input bit mmio);
        IN_sqValid = 1; IN_sqId = IDW'(id); IN_sqAddr = addr;
        IN_sqData = 32'hD000_0000 | addr; IN_sqWmask = 4'hF; IN_sqIsMMIO = mmio;
    endtask

    task automatic done(input int tag, input bit err);
        IN_wrDone = 1; IN_wrDoneTag = 2'(tag); IN_wrErr = err;
        tick();
        IN_wrDone = 0; IN_wrErr = 0;
    endtask

    initial begin
        int lst[$];
        rst = 1; quiet_inputs();
        IN_sqId = 0; IN_sqAddr = 0; IN_sqData = 0; IN_sqWmask = 0;
        IN_auxAddr = 32'hA000_0000; IN_auxData = 32'h1234_5678; IN_auxWmask = 4'h3;
        tick(); tick();
        rst = 0;
        chk("rst_wrValid", OUT_wrValid, 1'b0);
        chk("rst_idle", OUT_idle, 1'b1);
        chk("rst_ack", OUT_stAckValid, 1'b0);

        // single store, ack one cycle after completion
        sq_drive(5, 32'h1000, 0); #1;
        chk("t1_stall_accept", OUT_stallSq, 1'b0);
        tick(); IN_sqValid = 0;
        chk("t1_wrValid", OUT_wrValid, 1'b1);
        chk("t1_tag", OUT_wrTag, 2'd0);
        chk("t1_addr", OUT_wrAddr, 32'h1000);
        tick(); tick();
        done(0, 0);
        chk("t1_ack", OUT_stAckValid, 1'b1);
        chk("t1_ackId", OUT_stAckId, 6'd5);

        // tags exhausted, freed tag reusable only the cycle after
        for (int k = 1; k <= 4; k++) begin
            sq_drive(k, 32'(k << 4), 0); #1;
            chk("t2_stall_fill", OUT_stallSq, 1'b0);
            tick();
        end
        sq_drive(5, 32'h50, 0); #1;
        chk("t2_full_stall", OUT_stallSq, 1'b1);
        IN_wrDone = 1; IN_wrDoneTag = 2'd2; #1;
        chk("t2_free_same_cycle", OUT_stallSq, 1'b1);
        tick(); IN_wrDone = 0; #1;
        chk("t2_realloc", OUT_stallSq, 1'b0);
        tick(); IN_sqValid = 0;
        chk("t2_tag2", OUT_wrTag, 2'd2);
        done(0, 0); done(1, 0); done(3, 0); done(2, 0);

        // alternating arbitration
        IN_auxValid = 1;
        for (int k = 0; k < 4; k++) begin
            sq_drive(10 + k / 2, 32'h200 + 32'(k / 2) * 4, 0); #1;
            chk("t3_auxReady", OUT_auxReady, (k % 2) == 0);
            chk("t3_stall", OUT_stallSq, (k % 2) == 0);
            tick();
        end
        quiet_inputs();
        done(0, 0); done(1, 0); done(2, 0); done(3, 0);

        // MMIO ordering
        sq_drive(20, 32'h300, 0); tick();
        sq_drive(21, 32'h304, 0); tick();
        sq_drive(9, 32'h8000_0000, 1); #1;
        chk("t4_mmio_stall", OUT_stallSq, 1'b1);
        tick(); IN_auxValid = 1; #1;
        chk("t4_drain_aux", OUT_auxReady, 1'b0);
        tick();
        done(0, 0);
        IN_wrDone = 1; IN_wrDoneTag = 2'd1; #1;
        chk("t4_drain_stall", OUT_stallSq, 1'b1);
        tick(); IN_wrDone = 0; #1;
        chk("t4_mmio_issue", OUT_stallSq, 1'b0);
        tick(); IN_sqValid = 0; IN_sqIsMMIO = 0; #1;
        chk("t4_mmio_tag", OUT_wrTag, 2'd0);
        chk("t4_wait_aux", OUT_auxReady, 1'b0);
        tick();
        IN_wrDone = 1; IN_wrDoneTag = 2'd0; #1;
        chk("t4_wait_aux2", OUT_auxReady, 1'b0);
        tick(); IN_wrDone = 0; #1;
        chk("t4_run_aux", OUT_auxReady, 1'b1);
        tick(); IN_auxValid = 0;
        done(0, 0);

        // write port back-pressure
        sq_drive(30, 32'h400, 0); tick();
        IN_sqValid = 0; IN_wrReady = 0; IN_auxValid = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_hold_aux", OUT_auxReady, 1'b0);
            chk("t5_hold_addr", OUT_wrAddr, 32'h400);
            tick();
        end
        IN_auxValid = 0; IN_wrReady = 1; tick();
        done(0, 0);

        // bus error ack, then reset during MMIO_WAIT
        sq_drive(7, 32'h500, 0); tick(); IN_sqValid = 0; tick();
        done(0, 1);
        chk("t6_err_ack", OUT_stAckValid, 1'b1);
        chk("t6_err_id", OUT_stAckId, 6'd7);
        chk("t6_busErr", OUT_busErr, 1'b1);
        sq_drive(12, 32'h8000_0010, 1); #1;
        chk("t6_mmio_direct", OUT_stallSq, 1'b0);
        tick(); IN_sqValid = 0; IN_sqIsMMIO = 0; tick();
        rst = 1; tick(); rst = 0;
        chk("t6_rst_wrValid", OUT_wrValid, 1'b0);
        chk("t6_rst_idle", OUT_idle, 1'b1);
        done(0, 0);
        chk("t6_late_done", OUT_stAckValid, 1'b0);

        // random traffic
        quiet_inputs();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            rst = ($urandom_range(0, 599) == 0);
            if (!IN_sqValid || sqTaken) begin
                IN_sqValid  = ($urandom_range(0, 99) < 60);
                IN_sqId     = IDW'($urandom);
                IN_sqAddr   = $urandom & 32'hFFFF_FFFC;
                IN_sqData   = $urandom;
                IN_sqWmask  = 4'($urandom_range(0, 15));
                IN_sqIsMMIO = ($urandom_range(0, 7) == 0);
            end
            if (!IN_auxValid || auxTaken) begin
                IN_auxValid = ($urandom_range(0, 99) < 30);
                IN_auxAddr  = $urandom & 32'hFFFF_FFFC;
                IN_auxData  = $urandom;
                IN_auxWmask = 4'($urandom_range(0, 15));
            end
            IN_wrReady = ($urandom_range(0, 9) < 7);
            lst.delete();
            for (int i = 0; i < NT; i++) if (m_acc[i]) lst.push_back(i);
            IN_wrDone = 0; IN_wrErr = 0;
            if (lst.size() > 0 && $urandom_range(0, 99) < 40) begin
                IN_wrDone    = 1;
                IN_wrDoneTag = 2'(lst[$urandom_range(0, lst.size() - 1)]);
                IN_wrErr     = ($urandom_range(0, 9) == 0);
            end
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
